// File: rtl/playback_trace_pkg.sv
// Shared types and helpers for the playback trace buffer.
// Optional feature macro: PLAYBACK_TRACE_STAMP_EN (entries carry a cycle stamp).
package playback_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CAPT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

`ifdef PLAYBACK_TRACE_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    // Width of one stored entry: {in, out, rpt[, stamp]}
    function automatic int entry_width(input int in_w, input int out_w,
                                       input int rpt_w, input int stamp_w);
        return in_w + out_w + rpt_w + (STAMP_EN ? stamp_w : 0);
    endfunction

    // Saturation value of an rpt_w-bit run-length counter
    function automatic logic [63:0] rpt_max(input int rpt_w);
        return (64'd1 << rpt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/playback_trace_fifo.sv
// Synchronous FIFO with a registered head output. Push and pop may occur
// together at any level, including full. Storage is a plain array written
// without reset; the head register is the only read port.
module playback_trace_fifo
    import playback_trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     valid,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [AW:0]      w_count_next;

    assign full          = (r_count == (AW+1)'(DEPTH));
    assign w_pop         = pop & (r_count != '0);
    // A pop in the same cycle frees the slot the push needs
    assign w_push        = push & (~full | w_pop);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
    assign w_count_next  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    assign valid = (r_count != '0);
    assign dout  = r_head;
    assign level = r_count;

    // Storage write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Registered head: bypass the incoming word when it becomes the head
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
        end else if (w_count_next != '0) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
                r_head <= din;
            end else begin
                r_head <= r_mem[w_rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/playback_trace_buf.sv
// Trigger-gated trace capture: samples in_vec/out_vec each cycle, run-length
// compresses identical consecutive samples and queues entries for a
// valid/ready drain port.
// Optional feature macro: PLAYBACK_TRACE_STAMP_EN (cycle stamp per entry;
// when undefined the stamp counter is absent and rd_stamp reads 0).
module playback_trace_buf
    import playback_trace_pkg::*;
#(
    parameter int IN_W    = 269,
    parameter int OUT_W   = 198,
    parameter int DEPTH   = 16,
    parameter int RPT_W   = 8,
    parameter int STAMP_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     stop,
    input  logic [IN_W-1:0]          in_vec,
    input  logic [OUT_W-1:0]         out_vec,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [IN_W-1:0]          rd_in,
    output logic [OUT_W-1:0]         rd_out,
    output logic [RPT_W-1:0]         rd_rpt,
    output logic [STAMP_W-1:0]       rd_stamp,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy
);
    localparam int                 EW      = entry_width(IN_W, OUT_W, RPT_W, STAMP_W);
    localparam logic [RPT_W-1:0]   RPT_MAX = RPT_W'(rpt_max(RPT_W));

    state_t           r_state;
    logic             r_stg_valid;
    logic [IN_W-1:0]  r_stg_in;
    logic [OUT_W-1:0] r_stg_out;
    logic [RPT_W-1:0] r_stg_rpt;
    logic             r_overflow;

    logic             w_sample;
    logic             w_same;
    logic             w_cap_push;
    logic             w_flush_push;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic [EW-1:0]    w_push_data;
    logic [EW-1:0]    w_head;

`ifdef PLAYBACK_TRACE_STAMP_EN
    logic [STAMP_W-1:0] r_stamp;
    logic [STAMP_W-1:0] r_stg_stamp;

    // Free-running cycle stamp, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + STAMP_W'(1);
        end
    end

    // Stamp of the stage's first sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_stamp <= '0;
        end else if (w_sample && !(w_same && r_stg_rpt != RPT_MAX)) begin
            r_stg_stamp <= r_stamp;
        end
    end

    assign w_push_data = {r_stg_in, r_stg_out, r_stg_rpt, r_stg_stamp};
    assign rd_stamp    = w_head[STAMP_W-1:0];
`else
    assign w_push_data = {r_stg_in, r_stg_out, r_stg_rpt};
    assign rd_stamp    = '0;
`endif

    // The trig cycle itself is sampled; a stop cycle never is
    assign w_sample     = ((r_state == ST_ARMED && trig) || r_state == ST_CAPT) && !stop;
    assign w_same       = r_stg_valid && (in_vec == r_stg_in) && (out_vec == r_stg_out);
    assign w_cap_push   = w_sample && r_stg_valid && !(w_same && r_stg_rpt != RPT_MAX);
    assign w_pop        = rd_valid & rd_ready;
    // Flush never drops: it only pushes when the FIFO can take the entry
    assign w_flush_push = (r_state == ST_FLUSH) && r_stg_valid && (!w_fifo_full || w_pop);
    assign w_push       = w_cap_push | w_flush_push;

    playback_trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_push_data),
        .pop   (w_pop),
        .full  (w_fifo_full),
        .valid (rd_valid),
        .dout  (w_head),
        .level (level)
    );

    assign rd_in    = w_head[EW-1 -: IN_W];
    assign rd_out   = w_head[EW-IN_W-1 -: OUT_W];
    assign rd_rpt   = w_head[EW-IN_W-OUT_W-1 -: RPT_W];
    assign overflow = r_overflow;
    assign busy     = (r_state != ST_IDLE) || rd_valid || r_stg_valid;

    // Capture control state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (arm) r_state <= ST_ARMED;
                ST_ARMED: begin
                    if (stop)      r_state <= ST_IDLE;
                    else if (trig) r_state <= ST_CAPT;
                end
                ST_CAPT:  if (stop) r_state <= ST_FLUSH;
                ST_FLUSH: if (!r_stg_valid || w_flush_push) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Run-length stage: extend on repeat, reload on change or saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_stg_in    <= '0;
            r_stg_out   <= '0;
            r_stg_rpt   <= '0;
        end else if (w_sample) begin
            if (w_same && r_stg_rpt != RPT_MAX) begin
                r_stg_rpt <= r_stg_rpt + RPT_W'(1);
            end else begin
                r_stg_valid <= 1'b1;
                r_stg_in    <= in_vec;
                r_stg_out   <= out_vec;
                r_stg_rpt   <= '0;
            end
        end else if (w_flush_push) begin
            r_stg_valid <= 1'b0;
        end
    end

    // Sticky drop flag, cleared when a new capture is armed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (r_state == ST_IDLE && arm) begin
            r_overflow <= 1'b0;
        end else if (w_cap_push && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule
